// File: rtl/acc_bank.sv
// acc_bank: a bank of NUM_ACC independent accumulators, each REG_WIDTH bits wide.
// It sits between the ALU output and the processor bus.
//
// Each accepted command (write_en=1 while not busy) does one of the following
// to the accumulator chosen by sel: load, clear, increment, decrement, or a
// shift. A shift runs one bit per cycle over several cycles.
// The accumulator picked by the most recently accepted command drives both
// ALU and bus_out, combinationally.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   write_en          command strobe
//   op[2:0]           command code
//   sel[SEL_W-1:0]    target accumulator
//   shamt[SH_W-1:0]   shift amount for SHL/SHR
//   AC_in, bus_in     load data sources (sampled at the accept edge only)
//   ALU, bus_out      selected accumulator value
//   Zflag/Nflag/Cflag flags of the last completed operation
//   busy              shift in progress; commands are ignored
module acc_bank #(
    parameter int REG_WIDTH = 12,
    parameter int NUM_ACC   = 4,
    parameter int SEL_W     = 2,
    parameter int SH_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [2:0]           op,
    input  logic [SEL_W-1:0]     sel,
    input  logic [SH_W-1:0]      shamt,
    input  logic [REG_WIDTH-1:0] AC_in,
    input  logic [REG_WIDTH-1:0] bus_in,
    output logic [REG_WIDTH-1:0] ALU,
    output logic [REG_WIDTH-1:0] bus_out,
    output logic                 Zflag,
    output logic                 Nflag,
    output logic                 Cflag,
    output logic                 busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_LOAD_ALU = 3'b001;
    localparam logic [2:0] OP_LOAD_BUS = 3'b010;
    localparam logic [2:0] OP_CLR      = 3'b011;
    localparam logic [2:0] OP_INC      = 3'b100;
    localparam logic [2:0] OP_DEC      = 3'b101;
    localparam logic [2:0] OP_SHL      = 3'b110;
    localparam logic [2:0] OP_SHR      = 3'b111;

    // Shifting by REG_WIDTH already clears the register, so longer shifts are clamped.
    localparam logic [SH_W-1:0] MAX_STEPS = SH_W'(REG_WIDTH);

    state_t                 state_q, state_d;
    logic [REG_WIDTH-1:0]   acc_q [NUM_ACC];
    logic [REG_WIDTH-1:0]   acc_d [NUM_ACC];
    logic [SEL_W-1:0]       out_sel_q, out_sel_d;
    logic [SEL_W-1:0]       tgt_q, tgt_d;
    logic                   dir_q, dir_d;     // 1 = shift right
    logic [SH_W-1:0]        cnt_q, cnt_d;
    logic                   z_q, z_d, n_q, n_d, c_q, c_d;

    logic [REG_WIDTH-1:0]   cur;
    logic [REG_WIDTH-1:0]   res;
    logic [REG_WIDTH:0]     sum;

    always_comb begin
        state_d   = state_q;
        out_sel_d = out_sel_q;
        tgt_d     = tgt_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        for (int i = 0; i < NUM_ACC; i++) acc_d[i] = acc_q[i];
        cur = '0;
        res = '0;
        sum = '0;

        case (state_q)
            IDLE: begin
                if (write_en) begin
                    out_sel_d = sel;
                    cur       = acc_q[sel];
                    case (op)
                        OP_LOAD_ALU, OP_LOAD_BUS, OP_CLR: begin
                            if (op == OP_LOAD_ALU)      res = AC_in;
                            else if (op == OP_LOAD_BUS) res = bus_in;
                            else                        res = '0;
                            acc_d[sel] = res;
                            z_d = (res == '0);
                            n_d = res[REG_WIDTH-1];
                            c_d = 1'b0;
                        end
                        OP_INC: begin
                            sum = {1'b0, cur} + (REG_WIDTH+1)'(1);
                            res = sum[REG_WIDTH-1:0];
                            acc_d[sel] = res;
                            z_d = (res == '0);
                            n_d = res[REG_WIDTH-1];
                            c_d = sum[REG_WIDTH];
                        end
                        OP_DEC: begin
                            res = cur - REG_WIDTH'(1);
                            acc_d[sel] = res;
                            z_d = (res == '0);
                            n_d = res[REG_WIDTH-1];
                            c_d = (cur == '0);
                        end
                        OP_SHL, OP_SHR: begin
                            // A zero-length shift behaves exactly like NOP.
                            if (shamt != '0) begin
                                tgt_d   = sel;
                                dir_d   = (op == OP_SHR);
                                cnt_d   = (shamt > MAX_STEPS) ? MAX_STEPS : shamt;
                                state_d = SHIFT;
                            end
                        end
                        default: ; // NOP only moves the output select
                    endcase
                end
            end
            SHIFT: begin
                cur = acc_q[tgt_q];
                res = dir_q ? (cur >> 1) : (cur << 1);
                acc_d[tgt_q] = res;
                cnt_d = cnt_q - SH_W'(1);
                // Flags change only on the final step; C is the bit that step shifts out.
                if (cnt_q == SH_W'(1)) begin
                    state_d = IDLE;
                    z_d = (res == '0);
                    n_d = res[REG_WIDTH-1];
                    c_d = dir_q ? cur[0] : cur[REG_WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            out_sel_q <= '0;
            tgt_q     <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            out_sel_q <= out_sel_d;
            tgt_q     <= tgt_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign ALU     = acc_q[out_sel_q];
    assign bus_out = acc_q[out_sel_q];
    assign Zflag   = z_q;
    assign Nflag   = n_q;
    assign Cflag   = c_q;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_acc_bank.sv
// Testbench for acc_bank with the default parameters (12-bit width, 4 accumulators).
// The driver applies one cycle of stimulus at a time. For each cycle it updates
// a behavioural model and queues the outputs expected after the next rising edge.
// A separate monitor pops the queued expectations just after each rising edge
// and compares them with the DUT outputs.
module tb_acc_bank;

    localparam int W    = 12;
    localparam int MASK = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic [2:0]  op = '0;
    logic [1:0]  sel = '0;
    logic [3:0]  shamt = '0;
    logic [11:0] AC_in = '0;
    logic [11:0] bus_in = '0;
    logic [11:0] ALU, bus_out;
    logic        Zflag, Nflag, Cflag, busy;

    acc_bank dut (
        .clk(clk), .reset(reset), .write_en(write_en), .op(op), .sel(sel),
        .shamt(shamt), .AC_in(AC_in), .bus_in(bus_in), .ALU(ALU),
        .bus_out(bus_out), .Zflag(Zflag), .Nflag(Nflag), .Cflag(Cflag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int alu;
        bit z, n, c, busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state. A shift is held as its original value and its total step
    // count. Each intermediate value is then computed directly from those two.
    int m_acc [4];
    int m_sel;
    bit m_z, m_n, m_c;
    bit sh_active, sh_right;
    int sh_tgt, sh_orig, sh_k, sh_done;

    function automatic void model_edge(bit rst_i, bit we_i, int op_i, int sel_i,
                                       int sh_i, int ac_i, int bus_i);
        int v;
        if (rst_i) begin
            for (int i = 0; i < 4; i++) m_acc[i] = 0;
            m_sel = 0; m_z = 0; m_n = 0; m_c = 0; sh_active = 0;
            return;
        end
        if (sh_active) begin
            sh_done++;
            v = sh_right ? (sh_orig >> sh_done) : ((sh_orig << sh_done) & MASK);
            m_acc[sh_tgt] = v;
            if (sh_done == sh_k) begin
                sh_active = 0;
                m_z = (v == 0);
                m_n = v[W-1];
                m_c = sh_right ? ((sh_orig >> (sh_k - 1)) & 1)
                               : ((sh_orig >> (W - sh_k)) & 1);
            end
            return;
        end
        if (!we_i) return;
        m_sel = sel_i;
        v = m_acc[sel_i];
        case (op_i)
            1, 2, 3: begin
                v = (op_i == 1) ? ac_i : (op_i == 2) ? bus_i : 0;
                m_acc[sel_i] = v; m_z = (v == 0); m_n = v[W-1]; m_c = 0;
            end
            4: begin
                m_c = (v == MASK);
                v = (v + 1) & MASK;
                m_acc[sel_i] = v; m_z = (v == 0); m_n = v[W-1];
            end
            5: begin
                m_c = (v == 0);
                v = (v - 1) & MASK;
                m_acc[sel_i] = v; m_z = (v == 0); m_n = v[W-1];
            end
            6, 7: begin
                if (sh_i != 0) begin
                    sh_active = 1; sh_right = (op_i == 7); sh_tgt = sel_i;
                    sh_orig = v; sh_k = (sh_i > W) ? W : sh_i; sh_done = 0;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic step(bit rst_i, bit we_i, int op_i, int sel_i, int sh_i,
                        int ac_i, int bus_i);
        exp_t e;
        @(negedge clk);
        reset = rst_i; write_en = we_i; op = 3'(op_i); sel = 2'(sel_i);
        shamt = 4'(sh_i); AC_in = 12'(ac_i); bus_in = 12'(bus_i);
        model_edge(rst_i, we_i, op_i, sel_i, sh_i, ac_i, bus_i);
        e.alu = m_acc[m_sel]; e.z = m_z; e.n = m_n; e.c = m_c; e.busy = sh_active;
        exp_q.push_back(e);
    endtask

    task automatic cmd(int op_i, int sel_i, int sh_i, int data);
        step(0, 1, op_i, sel_i, sh_i, data, data);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(0, 0, $urandom_range(7), $urandom_range(3), $urandom_range(15),
                 $urandom_range(MASK), $urandom_range(MASK));
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (int'(ALU) != e.alu || int'(bus_out) != e.alu || Zflag != e.z ||
                Nflag != e.n || Cflag != e.c || busy != e.busy) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got alu=%h bus=%h Z%0b N%0b C%0b busy%0b, expected alu=%h Z%0b N%0b C%0b busy%0b",
                         vectors, $time, ALU, bus_out, Zflag, Nflag, Cflag, busy,
                         12'(e.alu), e.z, e.n, e.c, e.busy);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // Load into acc2, then move the output select away from it and back.
        cmd(2, 2, 0, 'hABC); cmd(0, 0, 0, 0); cmd(0, 2, 0, 0);
        // Increment wraps to zero, then decrement borrows back to all ones.
        cmd(1, 1, 0, 'hFFF); cmd(4, 1, 0, 0); cmd(5, 1, 0, 0);
        // SHL by 3 with a CLR issued mid-shift, which must be ignored.
        cmd(2, 3, 0, 'h801); cmd(6, 3, 3, 0); cmd(3, 3, 0, 0); idle(3);
        // SHR by 15 is clamped to 12 steps; then a zero-length shift acts as NOP.
        cmd(2, 0, 0, 'h800); cmd(7, 0, 15, 0); idle(13); cmd(7, 0, 0, 0);
        cmd(6, 1, 12, 0); idle(13);
        // Reset arriving during a 5-step shift, then a load right after it.
        cmd(1, 2, 0, 'h5A5); cmd(6, 2, 5, 0); idle(1);
        step(1, 1, 3, 2, 0, 0, 0);
        cmd(1, 2, 0, 'h123); idle(1);
        // write_en held high with back-to-back ops on alternating accumulators.
        for (int i = 0; i < 12; i++)
            cmd(1 + $urandom_range(4), i % 2, 0, $urandom_range(MASK));
        // write_en held high through a shift
        cmd(6, 0, 4, 0);
        for (int i = 0; i < 6; i++) cmd(4, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            step(r == 0, r < 70, $urandom_range(7), $urandom_range(3),
                 ($urandom_range(3) == 0) ? 0 : $urandom_range(15),
                 $urandom_range(MASK),
                 ($urandom_range(7) == 0) ? MASK : $urandom_range(MASK));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors still queued, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
